display_cathode_controller: RTL

DISPLAY_CATHODE_CONTROLLER -- requirements
Module: display_cathode_controller

---
 rtl/display_cathode_controller.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/display_cathode_controller.sv
// ---------------------------------------------------------------------------
// display_cathode_controller
//
// Purpose:
//   Drives the shared, active-low cathode lines of a four-digit multiplexed
//   seven-segment display. An external scanner supplies anodeNumber. The
//   cathodes are registered one digit ahead, so that they change on the same
//   edge as the anodes. Digit data lives in shadow registers. A requester
//   updates those registers through a req/ack handshake. The update is
//   committed only at a frame boundary, so no frame mixes old and new digits.
//   Optional leading-zero suppression is applied live from lz_en.
//
// Optional feature:
//   DISPLAY_BLINK_EN - when defined, adds the blink_mask port, a frame counter
//   and a blink phase register. Masked digits go fully dark during the odd
//   blink phase. When undefined, there is no blinking logic at all.
//
// Parameters:
//   BLINK_FRAMES    - display frames per blink half-period (1..65535)
//
// Ports:
//   clk_in          - system clock, the only clock
//   GSR             - synchronous active-high reset
//   anodeNumber     - digit whose anode is enabled this cycle (0,1,2,3,0...)
//   digits_in       - four hex codes, [3:0] is digit 0, [15:12] is digit 3
//   dp_in           - decimal point enables, bit k belongs to digit k
//   lz_en           - leading-zero suppression enable (level, live)
//   load_req        - update request, data held stable until load_ack
//   blink_mask      - (DISPLAY_BLINK_EN only) bit k blinks digit k
//   load_ack        - one-cycle pulse, shadow registers were updated
//   cathodeRegister - {dp,g,f,e,d,c,b,a}, active-low, registered
//   frame_start     - high whenever cathodeRegister carries digit 0
// ---------------------------------------------------------------------------
module display_cathode_controller #(
    parameter int BLINK_FRAMES = 256
) (
    input  logic        clk_in,
    input  logic        GSR,
    input  logic [1:0]  anodeNumber,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic        lz_en,
    input  logic        load_req,
`ifdef DISPLAY_BLINK_EN
    input  logic [3:0]  blink_mask,
`endif
    output logic        load_ack,
    output logic [7:0]  cathodeRegister,
    output logic        frame_start
);

    // Load handshake states
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ARMED = 2'd1;
    localparam logic [1:0] ACK   = 2'd2;

    // This block is elaborated only for an out-of-range BLINK_FRAMES. It then
    // shows up in the hierarchy as a visible marker of the bad setting.
    if (BLINK_FRAMES < 1 || BLINK_FRAMES > 65535) begin : gBlinkFramesOutOfRange
    end

    logic [1:0]  loadState;
    logic [15:0] shadowDigits;
    logic [3:0]  shadowDp;
    logic        capture;
    logic [15:0] srcDigits;
    logic [3:0]  srcDp;
    logic [1:0]  nextIndex;
    logic [3:0]  nextCode;
    logic        nextDp;
    logic        nextSuppress;
    logic        suppress1;
    logic        suppress2;
    logic        suppress3;
    logic [7:0]  nextPattern;
    logic        nextBlinkOff;

    // Standard numerals 0-9, a dash for A, and blank for B-F. The dp bit is
    // left off here and applied separately.
    function automatic logic [7:0] decodeHex(input logic [3:0] code);
        logic [7:0] seg;
        case (code)
            4'h0:    seg = 8'hC0;
            4'h1:    seg = 8'hF9;
            4'h2:    seg = 8'hA4;
            4'h3:    seg = 8'hB0;
            4'h4:    seg = 8'h99;
            4'h5:    seg = 8'h92;
            4'h6:    seg = 8'h82;
            4'h7:    seg = 8'hF8;
            4'h8:    seg = 8'h80;
            4'h9:    seg = 8'h90;
            4'hA:    seg = 8'hBF;
            default: seg = 8'hFF;
        endcase
        return seg;
    endfunction

    // Capture happens on the edge that also loads digit 0 of the next frame.
    // For that reason the decoder reads the incoming data directly during the
    // capture cycle. This keeps the whole new frame consistent.
    assign capture   = (loadState == ARMED) && load_req && (anodeNumber == 2'd3);
    assign srcDigits = capture ? digits_in : shadowDigits;
    assign srcDp     = capture ? dp_in : shadowDp;
    assign load_ack  = (loadState == ACK);

    // Cathodes lead the anodes by one position, so decode the digit the
    // scanner will select after this edge.
    assign nextIndex = anodeNumber + 2'd1;

    // Suppression ripples down from digit 3. A dash is not zero, so a dash
    // stops the ripple. Digit 0 is never suppressed.
    assign suppress3 = lz_en && (srcDigits[15:12] == 4'h0);
    assign suppress2 = suppress3 && (srcDigits[11:8] == 4'h0);
    assign suppress1 = suppress2 && (srcDigits[7:4] == 4'h0);

    // Load handshake: arm on request, then commit at the frame boundary.
    // Dropping the request while armed aborts the capture.
    always_ff @(posedge clk_in) begin
        if (GSR) begin
            loadState <= IDLE;
        end else begin
            case (loadState)
                IDLE:    if (load_req) loadState <= ARMED;
                ARMED: begin
                    if (!load_req)
                        loadState <= IDLE;
                    else if (anodeNumber == 2'd3)
                        loadState <= ACK;
                end
                ACK:     loadState <= IDLE;
                default: loadState <= IDLE;
            endcase
        end
    end

    // Shadow registers are the only source of display data. They reset to
    // blank codes with no decimal points.
    always_ff @(posedge clk_in) begin
        if (GSR) begin
            shadowDigits <= 16'hFFFF;
            shadowDp     <= 4'h0;
        end else if (capture) begin
            shadowDigits <= digits_in;
            shadowDp     <= dp_in;
        end
    end

`ifdef DISPLAY_BLINK_EN
    localparam logic [15:0] BLINK_LAST = 16'(BLINK_FRAMES - 1);

    logic [15:0] frameCount;
    logic        blinkPhase;

    // Count completed frame starts. Flip the phase every BLINK_FRAMES frames.
    always_ff @(posedge clk_in) begin
        if (GSR) begin
            frameCount <= 16'd0;
            blinkPhase <= 1'b0;
        end else if (frame_start) begin
            if (frameCount == BLINK_LAST) begin
                frameCount <= 16'd0;
                blinkPhase <= ~blinkPhase;
            end else begin
                frameCount <= frameCount + 16'd1;
            end
        end
    end

    assign nextBlinkOff = blinkPhase && blink_mask[nextIndex];
`else
    assign nextBlinkOff = 1'b0;
`endif

    // Select the code, dp bit and suppression flag for the upcoming digit.
    always_comb begin
        nextCode     = srcDigits[3:0];
        nextDp       = srcDp[0];
        nextSuppress = 1'b0;
        case (nextIndex)
            2'd1: begin
                nextCode     = srcDigits[7:4];
                nextDp       = srcDp[1];
                nextSuppress = suppress1;
            end
            2'd2: begin
                nextCode     = srcDigits[11:8];
                nextDp       = srcDp[2];
                nextSuppress = suppress2;
            end
            2'd3: begin
                nextCode     = srcDigits[15:12];
                nextDp       = srcDp[3];
                nextSuppress = suppress3;
            end
            default: begin
                nextCode     = srcDigits[3:0];
                nextDp       = srcDp[0];
                nextSuppress = 1'b0;
            end
        endcase
    end

    // The dp still lights on a suppressed digit. Blinking, however, darkens
    // everything, including the dp.
    always_comb begin
        nextPattern = nextSuppress ? 8'hFF : decodeHex(nextCode);
        if (nextDp)
            nextPattern[7] = 1'b0;
        if (nextBlinkOff)
            nextPattern = 8'hFF;
    end

    // Output registers.
    always_ff @(posedge clk_in) begin
        if (GSR) begin
            cathodeRegister <= 8'hFF;
            frame_start     <= 1'b0;
        end else begin
            cathodeRegister <= nextPattern;
            frame_start     <= (nextIndex == 2'd0);
        end
    end

endmodule
